ndata_pattern_driver: RTL and testbench
=======================================

// Module: ndata_pattern_driver
// PURPOSE
// Test-bench stream source that replays a table of DEPTH ndata beats onto an ndata_i master port.
// Packets are built from table entries 0..pkt_len-1, with last asserted on entry pkt_len-1.
// Supports cyclic, one-shot and counted modes, pseudo-random valid throttling, start/stop control and progress counters.
// Drives DUT inputs in block-level and integration benches.
// PARAMETERS
// DATA_W        32        bits per element
// NUM_ELEMENTS  4         elements per beat; width of keep
// DEPTH         8         table entries (beats); DEPTH >= 1
// LFSR_SEED     16'hACE1  non-zero reset value of the 16-bit throttle LFSR
// PORTS
// clk        in   1                          clock
// rst_n      in   1                          async active-low reset
// data_tbl   in   DEPTH*NUM_ELEMENTS*DATA_W  entry e, element k at [(e*NUM_ELEMENTS+k)*DATA_W +: DATA_W]
// keep_tbl   in   DEPTH*NUM_ELEMENTS         entry e keep at [e*NUM_ELEMENTS +: NUM_ELEMENTS]
// mode       in   2                          0 CYCLIC, 1 ONESHOT, 2 COUNT, 3 reserved (behaves as ONESHOT)
// pkt_len    in   $clog2(DEPTH+1)            beats per packet; 0 or >DEPTH clamps to DEPTH
// pkt_count  in   32                         packets to send in COUNT mode
// throttle   in   8                          gap probability: gap when lfsr[7:0] < throttle; 0 = none
// start      in   1                          1-cycle pulse; honoured in IDLE and DONE only
// stop       in   1                          1-cycle pulse; finish current packet, then DONE
// busy       out  1                          high in RUN
// done       out  1                          high in DONE until the next start
// beats_sent out  32                         accepted beats since start (wraps)
// pkts_sent  out  32                         accepted last beats since start (wraps)
// out_data   ndata_i.m  (DATA_W, NUM_ELEMENTS)  fields: valid, ready, data, keep, last
// BEHAVIOUR
// - Reset (async, immediate): state IDLE; out valid=0, data/keep/last=0; busy=0, done=0; counters=0; beat idx=0; lfsr=LFSR_SEED.
// - States: IDLE -start-> RUN; RUN -end condition-> DONE; DONE -start-> RUN. No other transitions.
// - On start: latch mode, clamped pkt_len, pkt_count and throttle. Clear idx, counters and any stop request.
//   In COUNT mode with pkt_count==0, go directly to DONE; valid never rises.
// - All outputs are registered. The earliest valid is the cycle after start.
// - Table contents are not latched. Entry idx is sampled when its beat is loaded into the output register.
// - Load rule in RUN: when (!valid || ready) and not ending:
//   - if gap: valid<=0;
//   - else: valid<=1 and present data/keep of entry idx, with last=(idx==pkt_len-1); idx advances.
//   - idx wraps to 0 after pkt_len-1.
// - Handshake: once valid=1, data/keep/last are held stable and valid is not dropped until ready=1.
//   Throttle gaps are inserted only between beats.
// - Transfer = valid&&ready. Each transfer increments beats_sent; a transfer with last=1 also increments pkts_sent.
// - LFSR: x^16+x^14+x^13+x^11+1 Fibonacci, advances every cycle in RUN. gap=(lfsr[7:0] < throttle).
// - End conditions, evaluated on a last-beat transfer. No further beat is loaded, valid drops the next cycle, then DONE:
//   - ONESHOT: first packet;
//   - COUNT: pkts_sent reaches pkt_count;
//   - CYCLIC: never, except by stop.
// - stop in RUN sets a sticky request. The packet in flight completes, then DONE.
//   If stop arrives when idx==0 and valid==0, go to DONE the next cycle.
//   stop in IDLE/DONE is ignored.
// - Simultaneous start and stop in IDLE/DONE: start wins, stop is ignored.
// - busy=(state==RUN); done=(state==DONE). beats_sent/pkts_sent hold their values in DONE.
// - Reset asserted mid-packet: valid drops asynchronously. The packet is truncated (no last); downstream must tolerate it.
// TESTING
// 1. DEPTH=4, pkt_len=4, ONESHOT, throttle=0, ready=1 -> beats e0..e3 on 4 consecutive cycles; last on e3; done; beats_sent=4, pkts_sent=1.
// 2. CYCLIC, pkt_len=3, ready=1, run 10 cycles -> sequence e0,e1,e2,e0,...; last every 3rd beat; stop mid-packet -> packet completes, then done.
// 3. COUNT, pkt_count=5, pkt_len=2, ready toggling 1/0 -> exactly 10 transfers and 5 last beats; data stable while valid&&!ready.
// 4. throttle=128, ready=1, 1000 cycles -> ~50% valid duty (40-60%); valid never drops while ready=0; beat order intact.
// 5. COUNT with pkt_count=0 -> done the cycle after start, valid stays 0. pkt_len=0 -> DEPTH beats per packet.
// 6. rst_n asserted mid-packet -> valid=0 immediately and all counters 0; subsequent start replays from entry 0.

Source files
------------

// File: rtl/ndata_pattern_driver_if.sv
// ndata stream interface: valid/ready handshake carrying
// NUM_ELEMENTS x DATA_W data, per-element keep and packet last.
interface ndata_i #(
    parameter int DATA_W       = 32,
    parameter int NUM_ELEMENTS = 4
);
    logic                           valid;
    logic                           ready;
    logic [NUM_ELEMENTS*DATA_W-1:0] data;
    logic [NUM_ELEMENTS-1:0]        keep;
    logic                           last;

    modport m (output valid, data, keep, last, input ready);
    modport s (input valid, data, keep, last, output ready);
endinterface

// File: rtl/ndata_pattern_driver.sv
// Table-driven ndata stream source with cyclic, one-shot and counted
// modes, LFSR valid throttling, stop control and progress counters.
module ndata_pattern_driver #(
    parameter int          DATA_W       = 32,
    parameter int          NUM_ELEMENTS = 4,
    parameter int          DEPTH        = 8,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [DEPTH*NUM_ELEMENTS*DATA_W-1:0] data_tbl,
    input  logic [DEPTH*NUM_ELEMENTS-1:0]        keep_tbl,
    input  logic [1:0]                          mode,
    input  logic [$clog2(DEPTH+1)-1:0]          pkt_len,
    input  logic [31:0]                         pkt_count,
    input  logic [7:0]                          throttle,
    input  logic                                start,
    input  logic                                stop,
    output logic                                busy,
    output logic                                done,
    output logic [31:0]                         beats_sent,
    output logic [31:0]                         pkts_sent,
    ndata_i.m                                   out_data
);
    localparam int LW = $clog2(DEPTH+1);
    localparam int BW = NUM_ELEMENTS*DATA_W;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [LW-1:0]           idx_q, len_q, len_in;
    logic [1:0]              mode_q;
    logic [31:0]             cnt_q;
    logic [7:0]              thr_q;
    logic                    stop_q;
    logic [15:0]             lfsr_q;
    logic                    valid_q, last_q;
    logic [BW-1:0]           data_q;
    logic [NUM_ELEMENTS-1:0] keep_q;
    logic                    xfer, stop_now, end_cond, finish;
    logic                    load, gap, go, idx_last;

    always_comb begin
        len_in   = (pkt_len == '0 || pkt_len > DEPTH_L) ? DEPTH_L : pkt_len;
        xfer     = valid_q && out_data.ready;
        stop_now = stop_q || stop;
        end_cond = (mode_q == 2'd2) ? (pkts_sent + 32'd1 == cnt_q)
                                    : (mode_q != 2'd0);
        finish   = (state_q == RUN) &&
                   ((xfer && last_q && (stop_now || end_cond)) ||
                    (stop_now && !valid_q && idx_q == '0));
        load     = (state_q == RUN) && (!valid_q || out_data.ready) && !finish;
        gap      = lfsr_q[7:0] < thr_q;
        go       = start && (state_q != RUN);
        idx_last = idx_q == len_q - LW'(1);
        state_d  = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start)
                    state_d = (mode == 2'd2 && pkt_count == '0) ? DONE : RUN;
            end
            RUN: begin
                if (finish) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            mode_q     <= '0;
            cnt_q      <= '0;
            thr_q      <= '0;
            stop_q     <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            data_q     <= '0;
            keep_q     <= '0;
            beats_sent <= '0;
            pkts_sent  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == RUN)
                lfsr_q <= {lfsr_q[14:0],
                           lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            if (go) begin
                mode_q     <= mode;
                len_q      <= len_in;
                cnt_q      <= pkt_count;
                thr_q      <= throttle;
                idx_q      <= '0;
                stop_q     <= 1'b0;
                beats_sent <= '0;
                pkts_sent  <= '0;
            end else if (state_q == RUN) begin
                if (stop) stop_q <= 1'b1;
                if (xfer) begin
                    beats_sent <= beats_sent + 32'd1;
                    if (last_q) pkts_sent <= pkts_sent + 32'd1;
                end
                if (finish) begin
                    valid_q <= 1'b0;
                end else if (load) begin
                    // Gaps only land here, i.e. never under an unaccepted beat
                    if (gap) begin
                        valid_q <= 1'b0;
                    end else begin
                        valid_q <= 1'b1;
                        data_q  <= data_tbl[int'(idx_q)*BW +: BW];
                        keep_q  <= keep_tbl[int'(idx_q)*NUM_ELEMENTS +: NUM_ELEMENTS];
                        last_q  <= idx_last;
                        idx_q   <= idx_last ? '0 : idx_q + LW'(1);
                    end
                end
            end
        end
    end

    assign out_data.valid = valid_q;
    assign out_data.data  = data_q;
    assign out_data.keep  = keep_q;
    assign out_data.last  = last_q;
    assign busy           = state_q == RUN;
    assign done           = state_q == DONE;
endmodule

// File: tb/tb_ndata_pattern_driver.sv
// Directed bench for ndata_pattern_driver: modes, stop, throttle,
// backpressure, clamping and asynchronous reset.
module tb_ndata_pattern_driver;
    localparam int DW = 8;
    localparam int NE = 2;
    localparam int DP = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [DP*NE*DW-1:0] data_tbl;
    logic [DP*NE-1:0] keep_tbl;
    logic [1:0]       mode = '0;
    logic [2:0]       pkt_len = '0;
    logic [31:0]      pkt_count = '0;
    logic [7:0]       throttle = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             busy, done;
    logic [31:0]      beats_sent, pkts_sent;
    int               checks = 0;
    int               passes = 0;

    ndata_i #(.DATA_W(DW), .NUM_ELEMENTS(NE)) bus ();

    ndata_pattern_driver #(
        .DATA_W(DW), .NUM_ELEMENTS(NE), .DEPTH(DP), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data_tbl(data_tbl), .keep_tbl(keep_tbl),
        .mode(mode), .pkt_len(pkt_len), .pkt_count(pkt_count),
        .throttle(throttle), .start(start), .stop(stop), .busy(busy),
        .done(done), .beats_sent(beats_sent), .pkts_sent(pkts_sent),
        .out_data(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_d(input int e);
        exp_d = {8'(e*16 + 2), 8'(e*16 + 1)};
    endfunction

    function automatic logic [1:0] exp_k(input int e);
        exp_k = (e == 3) ? 2'b01 : 2'b11;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        cyc();
        checks++; if (bus.valid !== 1'b0) $display("FAIL rst_valid got %b want 0", bus.valid); else passes++;
        checks++; if (bus.data !== 16'h0) $display("FAIL rst_data got %h want 0", bus.data); else passes++;
        checks++; if ({busy, done} !== 2'b00) $display("FAIL rst_state got %b want 00", {busy, done}); else passes++;
        checks++; if (beats_sent !== 0 || pkts_sent !== 0) $display("FAIL rst_cnt got %0d/%0d want 0/0", beats_sent, pkts_sent); else passes++;
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_oneshot();
        mode = 2'd1; pkt_len = 3'd4; throttle = 8'd0;
        pulse_start();
        checks++; if (busy !== 1'b1 || bus.valid !== 1'b0) $display("FAIL os_start got busy=%b valid=%b want 1 0", busy, bus.valid); else passes++;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++; if (bus.valid !== 1'b1 || bus.data !== exp_d(i) || bus.keep !== exp_k(i))
                $display("FAIL os_beat%0d got v=%b d=%h k=%b want 1 %h %b", i, bus.valid, bus.data, bus.keep, exp_d(i), exp_k(i)); else passes++;
            checks++; if (bus.last !== (i == 3)) $display("FAIL os_last%0d got %b want %b", i, bus.last, i == 3); else passes++;
        end
        cyc();
        checks++; if (bus.valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) $display("FAIL os_done got v=%b done=%b busy=%b want 0 1 0", bus.valid, done, busy); else passes++;
        checks++; if (beats_sent !== 4 || pkts_sent !== 1) $display("FAIL os_cnt got %0d/%0d want 4/1", beats_sent, pkts_sent); else passes++;
        stop = 1'b1; cyc(); stop = 1'b0; cyc();
        checks++; if (done !== 1'b1 || beats_sent !== 4) $display("FAIL os_stop_in_done got done=%b beats=%0d want 1 4", done, beats_sent); else passes++;
    endtask

    task automatic test_cyclic_stop();
        mode = 2'd0; pkt_len = 3'd3;
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            cyc();
            checks++; if (bus.valid !== 1'b1 || bus.data !== exp_d(i % 3) || bus.last !== (i % 3 == 2))
                $display("FAIL cyc_beat%0d got v=%b d=%h l=%b want 1 %h %b", i, bus.valid, bus.data, bus.last, exp_d(i % 3), i % 3 == 2); else passes++;
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        checks++; if (bus.data !== exp_d(1) || busy !== 1'b1) $display("FAIL cyc_stop1 got d=%h busy=%b want %h 1", bus.data, busy, exp_d(1)); else passes++;
        cyc();
        checks++; if (bus.data !== exp_d(2) || bus.last !== 1'b1) $display("FAIL cyc_stop2 got d=%h l=%b want %h 1", bus.data, bus.last, exp_d(2)); else passes++;
        cyc();
        checks++; if (done !== 1'b1 || bus.valid !== 1'b0) $display("FAIL cyc_done got done=%b v=%b want 1 0", done, bus.valid); else passes++;
        checks++; if (beats_sent !== 9 || pkts_sent !== 3) $display("FAIL cyc_cnt got %0d/%0d want 9/3", beats_sent, pkts_sent); else passes++;
    endtask

    task automatic test_count_backpressure();
        int ei = 0, lasts = 0, c = 0;
        logic pv = 1'b0, pr = 1'b0;
        mode = 2'd2; pkt_len = 3'd2; pkt_count = 32'd5;
        bus.ready = 1'b0;
        pulse_start();
        while (c < 100 && done !== 1'b1) begin
            cyc();
            c++;
            if (pv && !pr) begin
                checks++; if (bus.valid !== 1'b1) $display("FAIL cnt_hold_valid c=%0d got %b want 1", c, bus.valid); else passes++;
            end
            if (bus.valid === 1'b1) begin
                checks++; if (bus.data !== exp_d(ei % 2) || bus.last !== (ei % 2 == 1))
                    $display("FAIL cnt_beat c=%0d got d=%h l=%b want %h %b", c, bus.data, bus.last, exp_d(ei % 2), ei % 2 == 1); else passes++;
            end
            bus.ready = ~bus.ready;
            if (bus.valid === 1'b1 && bus.ready === 1'b1) begin
                if (bus.last === 1'b1) lasts++;
                ei++;
            end
            pv = bus.valid; pr = bus.ready;
        end
        checks++; if (done !== 1'b1) $display("FAIL cnt_timeout got done=%b want 1", done); else passes++;
        checks++; if (ei != 10 || lasts != 5) $display("FAIL cnt_xfers got %0d/%0d want 10/5", ei, lasts); else passes++;
        checks++; if (beats_sent !== 10 || pkts_sent !== 5) $display("FAIL cnt_cnt got %0d/%0d want 10/5", beats_sent, pkts_sent); else passes++;
        bus.ready = 1'b1;
    endtask

    task automatic test_throttle();
        int ei = 0, vc = 0, c = 0;
        mode = 2'd0; pkt_len = 3'd4; throttle = 8'd128;
        pulse_start();
        for (int i = 0; i < 1000; i++) begin
            cyc();
            if (bus.valid === 1'b1) begin
                checks++; if (bus.data !== exp_d(ei % 4)) $display("FAIL thr_order i=%0d got %h want %h", i, bus.data, exp_d(ei % 4)); else passes++;
                ei++; vc++;
            end
        end
        checks++; if (vc < 400 || vc > 600) $display("FAIL thr_duty got %0d want 400..600", vc); else passes++;
        stop = 1'b1; cyc(); stop = 1'b0;
        if (bus.valid === 1'b1) ei++;
        while (c < 40 && done !== 1'b1) begin
            cyc();
            c++;
            if (bus.valid === 1'b1) begin
                checks++; if (bus.data !== exp_d(ei % 4)) $display("FAIL thr_tail got %h want %h", bus.data, exp_d(ei % 4)); else passes++;
                ei++;
            end
        end
        checks++; if (done !== 1'b1) $display("FAIL thr_timeout got done=%b want 1", done); else passes++;
        checks++; if (beats_sent !== 32'(ei) || ei % 4 != 0) $display("FAIL thr_cnt got %0d want %0d (multiple of 4)", beats_sent, ei); else passes++;
        throttle = 8'd0;
    endtask

    task automatic test_boundaries();
        int n = 0, c = 0;
        logic lastseen = 1'b0;
        mode = 2'd2; pkt_count = 32'd0; pkt_len = 3'd2;
        pulse_start();
        checks++; if (done !== 1'b1 || busy !== 1'b0 || bus.valid !== 1'b0) $display("FAIL cnt0 got done=%b busy=%b v=%b want 1 0 0", done, busy, bus.valid); else passes++;
        cyc(); cyc();
        checks++; if (bus.valid !== 1'b0 || beats_sent !== 0) $display("FAIL cnt0_hold got v=%b beats=%0d want 0 0", bus.valid, beats_sent); else passes++;
        mode = 2'd1; pkt_len = 3'd0;
        pulse_start();
        while (c < 20 && done !== 1'b1) begin
            cyc();
            c++;
            if (bus.valid === 1'b1) begin
                checks++; if (bus.data !== exp_d(n)) $display("FAIL len0_beat%0d got %h want %h", n, bus.data, exp_d(n)); else passes++;
                lastseen = bus.last;
                n++;
            end
        end
        checks++; if (n != 4 || lastseen !== 1'b1 || beats_sent !== 4) $display("FAIL len0 got n=%0d last=%b beats=%0d want 4 1 4", n, lastseen, beats_sent); else passes++;
    endtask

    task automatic test_reset_midpacket();
        mode = 2'd0; pkt_len = 3'd3;
        pulse_start();
        cyc(); cyc(); cyc();
        checks++; if (bus.valid !== 1'b1 || bus.data !== exp_d(2)) $display("FAIL mid_pre got v=%b d=%h want 1 %h", bus.valid, bus.data, exp_d(2)); else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.valid !== 1'b0 || busy !== 1'b0) $display("FAIL mid_rst got v=%b busy=%b want 0 0", bus.valid, busy); else passes++;
        checks++; if (beats_sent !== 0 || pkts_sent !== 0) $display("FAIL mid_rst_cnt got %0d/%0d want 0/0", beats_sent, pkts_sent); else passes++;
        cyc();
        rst_n = 1'b1;
        mode = 2'd1; pkt_len = 3'd2;
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        checks++; if (busy !== 1'b1) $display("FAIL start_stop got busy=%b want 1", busy); else passes++;
        cyc();
        checks++; if (bus.valid !== 1'b1 || bus.data !== exp_d(0)) $display("FAIL replay0 got v=%b d=%h want 1 %h", bus.valid, bus.data, exp_d(0)); else passes++;
        cyc();
        checks++; if (bus.data !== exp_d(1) || bus.last !== 1'b1) $display("FAIL replay1 got d=%h l=%b want %h 1", bus.data, bus.last, exp_d(1)); else passes++;
        cyc();
        checks++; if (done !== 1'b1 || beats_sent !== 2 || pkts_sent !== 1) $display("FAIL replay_done got done=%b %0d/%0d want 1 2/1", done, beats_sent, pkts_sent); else passes++;
    endtask

    initial begin
        bus.ready = 1'b1;
        for (int e = 0; e < DP; e++) begin
            for (int k = 0; k < NE; k++)
                data_tbl[(e*NE + k)*DW +: DW] = 8'(e*16 + k + 1);
            keep_tbl[e*NE +: NE] = (e == 3) ? 2'b01 : 2'b11;
        end
        test_reset();
        test_oneshot();
        test_cyclic_stop();
        test_count_backpressure();
        test_throttle();
        test_boundaries();
        test_reset_midpacket();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
